// File: rtl/inst_buffer.sv
// Circular instruction buffer between IF1 and decode: up to 4 pushes, up to 2 pops per cycle.
// Optional `IB_BYPASS_EN`: forwards pushes straight to decode when the buffer is empty.
module inst_buffer #(
  parameter int DATA_WD    = 82,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_IF,
  input  logic [4*DATA_WD-1:0]    if1_to_ib,
  input  logic [2:0]              push_num,
  output logic [DEPTH_LOG2:0]     can_push_size,
  output logic [2*DATA_WD-1:0]    ib_to_id,
  output logic [1:0]              ib_valid,
  input  logic [1:0]              id_pop_num
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DATA_WD-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rptr, wptr, rptr_hi;
  logic [DEPTH_LOG2-1:0] rptr_adv, wptr_adv;
  logic [CW-1:0]         count, push_sum, count_next;
  logic                  push_ok;
  logic [2:0]            push_acc, skip;
  logic [1:0]            avail, eff_pop;
  logic [3:0]            wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr [4];

  // A push is all-or-nothing: the sum's MSB set means it would reach DEPTH.
  assign push_sum      = count + CW'(push_num);
  assign push_ok       = ~push_sum[CW-1];
  assign push_acc      = push_ok ? push_num : 3'd0;
  assign rptr_hi       = rptr + DEPTH_LOG2'(1);
  assign can_push_size = count;

`ifdef IB_BYPASS_EN
  logic bypass;
  assign bypass = (count == '0) && push_ok;
`endif

  always_comb begin
    ib_valid = {count >= CW'(2), count != '0};
    ib_to_id = {mem[rptr_hi], mem[rptr]};
    skip     = 3'd0;
`ifdef IB_BYPASS_EN
    if (bypass) begin
      ib_valid = {push_num >= 3'd2, push_num != 3'd0};
      ib_to_id = if1_to_ib[2*DATA_WD-1:0];
    end
`endif
    avail   = 2'(ib_valid[0]) + 2'(ib_valid[1]);
    eff_pop = (id_pop_num > avail) ? avail : id_pop_num;
    rptr_adv = DEPTH_LOG2'(eff_pop);
`ifdef IB_BYPASS_EN
    // Entries consumed straight off the push bus never touch the array.
    if (bypass) begin
      skip     = 3'(eff_pop);
      rptr_adv = '0;
    end
`endif
    wptr_adv   = DEPTH_LOG2'(push_acc - skip);
    count_next = count + CW'(push_acc) - CW'(eff_pop);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_en[k]   = (3'(k) < push_acc) && (3'(k) >= skip) && !flush_IF;
      wr_addr[k] = wptr + DEPTH_LOG2'(k) - DEPTH_LOG2'(skip);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem[wr_addr[k]] <= if1_to_ib[k*DATA_WD +: DATA_WD];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_IF) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + rptr_adv;
      wptr  <= wptr + wptr_adv;
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: a queue model of buffered entries, checked every cycle.
module tb_inst_buffer;

  localparam int DATA_WD    = 82;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush_IF = 1'b0;
  logic [4*DATA_WD-1:0]  if1_to_ib = '0;
  logic [2:0]            push_num = 3'd0;
  logic [DEPTH_LOG2:0]   can_push_size;
  logic [2*DATA_WD-1:0]  ib_to_id;
  logic [1:0]            ib_valid;
  logic [1:0]            id_pop_num = 2'd0;

  logic [DATA_WD-1:0] sb [$];
  int                 tb_wptr = 0;
  int                 test_count = 0;
  int                 fail_count = 0;
  logic [31:0]        next_pc = 32'h1c000000;
  logic [31:0]        base_pc;

  always #5 clk = ~clk;

  inst_buffer #(.DATA_WD(DATA_WD), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_IF(flush_IF),
    .if1_to_ib(if1_to_ib),
    .push_num(push_num),
    .can_push_size(can_push_size),
    .ib_to_id(ib_to_id),
    .ib_valid(ib_valid),
    .id_pop_num(id_pop_num)
  );

  task automatic checkOutput(input string tag, input logic [DATA_WD-1:0] got,
                             input logic [DATA_WD-1:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_WD-1:0] make_entry(input logic [31:0] pc);
    logic [17:0] meta;
    meta = 18'($urandom);
    return {meta, pc, 32'($urandom)};
  endfunction

  // One cycle: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic applyStimulus(input int pn, input int pop, input logic fl);
    logic [DATA_WD-1:0] slot [4];
    int   size, avail, eff, stored;
    logic accepted, byp;
    for (int k = 0; k < 4; k++) begin
      slot[k] = (k < pn) ? make_entry(next_pc + 32'(4 * k)) : '0;
      if1_to_ib[k*DATA_WD +: DATA_WD] = slot[k];
    end
    next_pc    = next_pc + 32'(4 * pn);
    push_num   = 3'(pn);
    id_pop_num = 2'(pop);
    flush_IF   = fl;
    size     = sb.size();
    accepted = (size + pn <= DEPTH - 1);
`ifdef IB_BYPASS_EN
    byp = (size == 0) && accepted;
`else
    byp = 1'b0;
`endif
    if (byp) avail = (pn >= 2) ? 2 : pn;
    else     avail = (size >= 2) ? 2 : size;
    eff = (pop < avail) ? pop : avail;

    @(negedge clk);
    checkOutput("can_push_size", DATA_WD'(can_push_size), DATA_WD'(size));
    checkOutput("ib_valid", DATA_WD'(ib_valid), DATA_WD'({avail >= 2, avail >= 1}));
    for (int i = 0; i < avail; i++)
      checkOutput((i == 0) ? "entry_lo" : "entry_hi", ib_to_id[i*DATA_WD +: DATA_WD],
                  byp ? slot[i] : sb[i]);

    @(posedge clk);
    if (!rst_n || fl) begin
      sb.delete();
      tb_wptr = 0;
    end else begin
      stored = 0;
      if (byp) begin
        for (int k = eff; k < pn; k++) sb.push_back(slot[k]);
        stored = pn - eff;
      end else begin
        for (int i = 0; i < eff; i++) void'(sb.pop_front());
        if (accepted) begin
          for (int k = 0; k < pn; k++) sb.push_back(slot[k]);
          stored = pn;
        end
      end
      tb_wptr = (tb_wptr + stored) % DEPTH;
    end
    #1;
    push_num   = 3'd0;
    id_pop_num = 2'd0;
    flush_IF   = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cps", DATA_WD'(can_push_size), '0);
    checkOutput("reset_valid", DATA_WD'(ib_valid), '0);
    rst_n = 1'b1;

    applyStimulus(4, 0, 1'b0);
    checkOutput("first_push_cps", DATA_WD'(can_push_size), DATA_WD'(4));
    checkOutput("first_push_valid", DATA_WD'(ib_valid), DATA_WD'(2'b11));
    checkOutput("first_push_pc_lo", DATA_WD'(ib_to_id[63:32]), DATA_WD'(32'h1c000000));
    checkOutput("first_push_pc_hi", DATA_WD'(ib_to_id[DATA_WD+63:DATA_WD+32]),
                DATA_WD'(32'h1c000004));

    applyStimulus(4, 0, 1'b0);
    applyStimulus(4, 0, 1'b0);
    applyStimulus(1, 0, 1'b0);
    checkOutput("fill_13", DATA_WD'(can_push_size), DATA_WD'(13));
    applyStimulus(2, 0, 1'b0);
    checkOutput("fill_15", DATA_WD'(can_push_size), DATA_WD'(15));
    applyStimulus(1, 0, 1'b0);
    checkOutput("full_drop", DATA_WD'(can_push_size), DATA_WD'(15));
    applyStimulus(4, 2, 1'b0);
    checkOutput("full_pop_drop", DATA_WD'(can_push_size), DATA_WD'(13));

    repeat (8) applyStimulus(0, 2, 1'b0);
    applyStimulus(1, 0, 1'b0);
    applyStimulus(0, 2, 1'b0);
    checkOutput("clamp_cps", DATA_WD'(can_push_size), '0);
    checkOutput("clamp_valid", DATA_WD'(ib_valid), '0);

    for (int i = 0; i < 32 && tb_wptr != 14; i++) begin
      if (sb.size() >= DEPTH - 1) applyStimulus(0, 2, 1'b0);
      else                        applyStimulus(1, 0, 1'b0);
    end
    repeat (8) applyStimulus(0, 2, 1'b0);
    repeat (4) applyStimulus(4, 2, 1'b0);
    repeat (9) applyStimulus(0, 2, 1'b0);
    checkOutput("wrap_drained", DATA_WD'(can_push_size), '0);

    applyStimulus(4, 0, 1'b0);
    applyStimulus(4, 0, 1'b0);
    applyStimulus(1, 0, 1'b0);
    checkOutput("pre_flush_cps", DATA_WD'(can_push_size), DATA_WD'(9));
    applyStimulus(3, 2, 1'b1);
    checkOutput("flush_cps", DATA_WD'(can_push_size), '0);
    checkOutput("flush_valid", DATA_WD'(ib_valid), '0);
    base_pc = next_pc;
    applyStimulus(1, 0, 1'b0);
    checkOutput("post_flush_cps", DATA_WD'(can_push_size), DATA_WD'(1));
    checkOutput("post_flush_pc", DATA_WD'(ib_to_id[63:32]), DATA_WD'(base_pc));

`ifdef IB_BYPASS_EN
    applyStimulus(0, 2, 1'b0);
    base_pc = next_pc;
    applyStimulus(3, 2, 1'b0);
    checkOutput("bypass_cps", DATA_WD'(can_push_size), DATA_WD'(1));
    checkOutput("bypass_head_pc", DATA_WD'(ib_to_id[63:32]), DATA_WD'(base_pc + 32'd8));
`endif

    for (int i = 0; i < 300; i++) begin
      if (i == 150) rst_n = 1'b0;
      applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 19) == 0));
      if (i == 150) begin
        rst_n = 1'b1;
        checkOutput("midrun_reset_cps", DATA_WD'(can_push_size), '0);
        checkOutput("midrun_reset_valid", DATA_WD'(ib_valid), '0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
